// File: rtl/ram_port_arbiter_pkg.sv
// ram_port_arbiter_pkg: shared types and constants for the image RAM port arbiter.
package ram_port_arbiter_pkg;

   // Default RAM geometry: byte-wide words, 17-bit address covering the image region.
   localparam int unsigned DATA_WIDTH_DEF  = 8;
   localparam int unsigned ADDR_WIDTH_DEF  = 17;

   // First address of the image buffer inside the RAM.
   localparam int unsigned IMAGE_BASE_ADDR = 20;

   // IDLE arbitrates every cycle; LOCKn means port n owns the RAM for a burst.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_t;

   // Lock state that corresponds to a given owning port.
   function automatic arb_state_t lock_state(input logic port);
      return port ? LOCK1 : LOCK0;
   endfunction

   // Owning port of a lock state (only meaningful when the state is not IDLE).
   function automatic logic lock_owner(input arb_state_t state);
      return (state == LOCK1);
   endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// ram_port_arbiter_if: requester-side bus of the arbiter (two access ports plus shared read data).
interface ram_port_arbiter_if
   import ram_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
);

   // Port 0: convolution core
   logic                  req0;
   logic                  we0;
   logic                  lock0;
   logic [ADDR_WIDTH-1:0] addr0;
   logic [DATA_WIDTH-1:0] wdata0;
   logic                  gnt0;
   logic                  rvalid0;

   // Port 1: image load/dump DMA
   logic                  req1;
   logic                  we1;
   logic                  lock1;
   logic [ADDR_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  gnt1;
   logic                  rvalid1;

   // Read data shared by both ports, qualified by rvalid0/rvalid1
   logic [DATA_WIDTH-1:0] rdata;

   // Requester view (both requesters together, as the bench or a wrapper drives them)
   modport master (
      output req0, we0, lock0, addr0, wdata0,
      output req1, we1, lock1, addr1, wdata1,
      input  gnt0, rvalid0, gnt1, rvalid1, rdata
   );

   // Arbiter view
   modport slave (
      input  req0, we0, lock0, addr0, wdata0,
      input  req1, we1, lock1, addr1, wdata1,
      output gnt0, rvalid0, gnt1, rvalid1, rdata
   );

endinterface

// File: rtl/ram_port_arbiter_rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker; on contention the port that
// did not win last time is granted.
module rr_pick2
   import ram_port_arbiter_pkg::*;
(
   input  logic [1:0] i_req,
   input  logic       i_last,
   output logic [1:0] o_gnt
);

   // Pick at most one requester, favouring the port other than i_last on a tie
   always_comb begin
      o_gnt = 2'b00;
      case (i_req)
         2'b01:   o_gnt = 2'b01;
         2'b10:   o_gnt = 2'b10;
         2'b11:   o_gnt = i_last ? 2'b01 : 2'b10;
         default: o_gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares the single-port image RAM between the convolution core (port 0)
// and the load/dump DMA (port 1). Round-robin with optional burst lock, bounded by MAX_LOCK
// consecutive locked grants while the other port waits. Grants and the RAM command are
// combinational; read-valid is registered to line up with the RAM's 1-cycle read.
module ram_port_arbiter
   import ram_port_arbiter_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int unsigned MAX_LOCK   = 64
) (
   input  logic                  clk,
   input  logic                  reset,
   ram_port_arbiter_if.slave     bus,
   output logic                  ram_w_en,
   output logic                  ram_r_en,
   output logic [ADDR_WIDTH-1:0] ram_address,
   output logic [DATA_WIDTH-1:0] ram_data_in,
   input  logic [DATA_WIDTH-1:0] ram_data_out,
   output logic                  busy
);

   localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

   // Registered state
   arb_state_t            r_state;
   logic                  r_last;
   logic [CNT_W-1:0]      r_lock_cnt;
   logic                  r_rvalid0;
   logic                  r_rvalid1;
   logic [ADDR_WIDTH-1:0] r_addr_hold;
   logic [DATA_WIDTH-1:0] r_wdata_hold;

   // Combinational decode
   logic [1:0]            w_req;
   logic [1:0]            w_we;
   logic [1:0]            w_lock;
   logic                  w_owner;
   logic                  w_cnt_full;
   logic                  w_starve;
   logic                  w_arb_last;
   logic [1:0]            w_pick;
   logic                  w_arbitrate;
   logic [1:0]            w_gnt;
   logic                  w_any_gnt;
   logic                  w_sel;
   logic [ADDR_WIDTH-1:0] w_addr_sel;
   logic [DATA_WIDTH-1:0] w_wdata_sel;
   arb_state_t            w_state_nxt;
   logic                  w_last_nxt;
   logic [CNT_W-1:0]      w_cnt_nxt;

   assign w_req  = {bus.req1,  bus.req0};
   assign w_we   = {bus.we1,   bus.we0};
   assign w_lock = {bus.lock1, bus.lock0};

   // In a lock state the owner counts as the last winner, so a fallback
   // re-arbitration hands a waiting peer the RAM in the same cycle.
   assign w_owner    = lock_owner(r_state);
   assign w_arb_last = (r_state == IDLE) ? r_last : w_owner;
   assign w_cnt_full = (r_lock_cnt == CNT_W'(MAX_LOCK));
   assign w_starve   = w_cnt_full & w_req[~w_owner];

   rr_pick2 u_pick (
      .i_req  (w_req),
      .i_last (w_arb_last),
      .o_gnt  (w_pick)
   );

   // Grant decision and next state: keep a live lock, otherwise fall back to round-robin
   always_comb begin
      w_gnt       = 2'b00;
      w_arbitrate = 1'b0;
      w_state_nxt = r_state;
      w_last_nxt  = r_last;
      w_cnt_nxt   = r_lock_cnt;

      if (reset) begin
         w_gnt = 2'b00;
      end else if (r_state == IDLE) begin
         w_arbitrate = 1'b1;
      end else if (w_req[w_owner] && w_lock[w_owner] && !w_starve) begin
         w_gnt[w_owner] = 1'b1;
         w_cnt_nxt      = w_cnt_full ? r_lock_cnt : r_lock_cnt + CNT_W'(1);
      end else begin
         // Lock dropped, owner idle, or the peer has waited MAX_LOCK grants
         w_arbitrate = 1'b1;
      end

      if (w_arbitrate) begin
         w_gnt       = w_pick;
         w_state_nxt = IDLE;
         w_cnt_nxt   = '0;
         if (w_pick != 2'b00) begin
            w_last_nxt = w_pick[1];
            if (w_lock[w_pick[1]]) begin
               w_state_nxt = lock_state(w_pick[1]);
               w_cnt_nxt   = CNT_W'(1);
            end
         end
      end
   end

   // RAM command mux from the granted port; address/data hold when nobody is granted
   assign w_any_gnt   = |w_gnt;
   assign w_sel       = w_gnt[1];
   assign w_addr_sel  = w_sel ? bus.addr1  : bus.addr0;
   assign w_wdata_sel = w_sel ? bus.wdata1 : bus.wdata0;

   assign ram_w_en    = w_any_gnt &  w_we[w_sel];
   assign ram_r_en    = w_any_gnt & ~w_we[w_sel];
   assign ram_address = w_any_gnt ? w_addr_sel  : r_addr_hold;
   assign ram_data_in = w_any_gnt ? w_wdata_sel : r_wdata_hold;

   // Arbitration state, round-robin pointer and lock run length
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= IDLE;
         r_last     <= 1'b1;
         r_lock_cnt <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_last     <= w_last_nxt;
         r_lock_cnt <= w_cnt_nxt;
      end
   end

   // Read-valid pipeline aligned with the RAM's registered read
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rvalid0 <= 1'b0;
         r_rvalid1 <= 1'b0;
      end else begin
         r_rvalid0 <= w_gnt[0] & ~w_we[0];
         r_rvalid1 <= w_gnt[1] & ~w_we[1];
      end
   end

   // Remember the last driven address/data so the RAM inputs stay quiet between grants
   always_ff @(posedge clk) begin
      if (reset) begin
         r_addr_hold  <= '0;
         r_wdata_hold <= '0;
      end else if (w_any_gnt) begin
         r_addr_hold  <= w_addr_sel;
         r_wdata_hold <= w_wdata_sel;
      end
   end

   assign bus.gnt0    = w_gnt[0];
   assign bus.gnt1    = w_gnt[1];
   assign bus.rvalid0 = r_rvalid0;
   assign bus.rvalid1 = r_rvalid1;
   assign bus.rdata   = ram_data_out;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter: directed scenarios plus randomized traffic against a
// rule-level model of the arbiter (owner / run length / last winner) and a byte memory.
module tb_ram_port_arbiter;
   import ram_port_arbiter_pkg::*;

   localparam int DW         = 8;
   localparam int AW         = 17;
   localparam int LOCK_LIMIT = 4;
   localparam int RAM_WORDS  = 1 << AW;

   logic          clk;
   logic          reset;
   logic          ram_w_en;
   logic          ram_r_en;
   logic [AW-1:0] ram_address;
   logic [DW-1:0] ram_data_in;
   logic [DW-1:0] ram_data_out;
   logic          busy;

   // Requester stimulus
   logic [1:0]    t_req;
   logic [1:0]    t_we;
   logic [1:0]    t_lock;
   logic [AW-1:0] t_addr  [2];
   logic [DW-1:0] t_wdata [2];

   // RAM attached to the DUT, and the model's own view of memory contents
   logic [DW-1:0] ram     [RAM_WORDS];
   logic [DW-1:0] ref_mem [RAM_WORDS];

   // Reference model state
   int            m_owner;
   int            m_run;
   int            m_last;
   logic [AW-1:0] m_hold_addr;
   bit            m_hold_ok;
   int            exp_g;
   bit            exp_cont;
   logic          exp_rv0;
   logic          exp_rv1;
   logic [DW-1:0] exp_rdata;

   int            n_tests;
   int            n_fail;

   ram_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   assign bus.req0   = t_req[0];
   assign bus.we0    = t_we[0];
   assign bus.lock0  = t_lock[0];
   assign bus.addr0  = t_addr[0];
   assign bus.wdata0 = t_wdata[0];
   assign bus.req1   = t_req[1];
   assign bus.we1    = t_we[1];
   assign bus.lock1  = t_lock[1];
   assign bus.addr1  = t_addr[1];
   assign bus.wdata1 = t_wdata[1];

   ram_port_arbiter #(
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .MAX_LOCK   (LOCK_LIMIT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .bus          (bus),
      .ram_w_en     (ram_w_en),
      .ram_r_en     (ram_r_en),
      .ram_address  (ram_address),
      .ram_data_in  (ram_data_in),
      .ram_data_out (ram_data_out),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single-port RAM with a registered read
   always @(posedge clk) begin
      if (ram_w_en) ram[ram_address] <= ram_data_in;
      if (ram_r_en) ram_data_out <= ram[ram_address];
   end

   task automatic idle_inputs();
      t_req  = 2'b00;
      t_we   = 2'b00;
      t_lock = 2'b00;
      for (int p = 0; p < 2; p++) begin
         t_addr[p]  = '0;
         t_wdata[p] = '0;
      end
   endtask

   // Expected grant for the current inputs, from the arbitration rules
   task automatic predict();
      int lastp;
      exp_g    = -1;
      exp_cont = 0;
      if (!reset) begin
         if (m_owner >= 0 && t_req[m_owner] && t_lock[m_owner] &&
             !(m_run >= LOCK_LIMIT && t_req[1 - m_owner])) begin
            exp_g    = m_owner;
            exp_cont = 1;
         end else begin
            lastp = (m_owner >= 0) ? m_owner : m_last;
            if (t_req == 2'b11)  exp_g = 1 - lastp;
            else if (t_req[0])   exp_g = 0;
            else if (t_req[1])   exp_g = 1;
         end
      end
   endtask

   // Advance the model across a clock edge
   task automatic model_update();
      if (reset) begin
         m_owner   = -1;
         m_last    = 1;
         m_run     = 0;
         exp_rv0   = 1'b0;
         exp_rv1   = 1'b0;
         m_hold_ok = 0;
      end else begin
         exp_rv0 = (exp_g == 0) && !t_we[0];
         exp_rv1 = (exp_g == 1) && !t_we[1];
         if (exp_g >= 0) begin
            if (t_we[exp_g]) ref_mem[t_addr[exp_g]] = t_wdata[exp_g];
            else             exp_rdata = ref_mem[t_addr[exp_g]];
            m_hold_addr = t_addr[exp_g];
            m_hold_ok   = 1;
            if (exp_cont) begin
               m_run = (m_run < LOCK_LIMIT) ? m_run + 1 : LOCK_LIMIT;
            end else begin
               m_last  = exp_g;
               m_owner = t_lock[exp_g] ? exp_g : -1;
               m_run   = 1;
            end
         end else begin
            m_owner = -1;
            m_run   = 0;
         end
      end
   endtask

   task automatic settle();
      #1;
      predict();
   endtask

   task automatic edge_update();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic to_neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle_inputs();
      for (int i = 0; i < 2; i++) begin
         settle();
         edge_update();
         to_neg();
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      t_req = 2'b11;
      for (int i = 0; i < 2; i++) begin
         settle();
         n_tests++;
         if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt: got gnt1/0=%b%b want 00", bus.gnt1, bus.gnt0);
         end
         n_tests++;
         if (ram_w_en !== 1'b0 || ram_r_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_en: got w/r=%b%b want 00", ram_w_en, ram_r_en);
         end
         edge_update();
         to_neg();
      end
      reset = 1'b0;
      idle_inputs();
      settle();
      edge_update();
      n_tests++;
      if (busy !== 1'b0 || bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_outs: got busy=%b rv0=%b rv1=%b want 000", busy, bus.rvalid0, bus.rvalid1);
      end
      to_neg();
   endtask

   task automatic test_single_read();
      idle_inputs();
      t_req[0]  = 1'b1;
      t_addr[0] = AW'(IMAGE_BASE_ADDR);
      settle();
      n_tests++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_gnt: got gnt1/0=%b%b want 01", bus.gnt1, bus.gnt0);
      end
      n_tests++;
      if (ram_r_en !== 1'b1 || ram_w_en !== 1'b0 || ram_address !== AW'(IMAGE_BASE_ADDR)) begin
         n_fail++;
         $display("FAIL rd_cmd: got r=%b w=%b addr=%0d want r=1 w=0 addr=%0d",
                  ram_r_en, ram_w_en, ram_address, IMAGE_BASE_ADDR);
      end
      edge_update();
      n_tests++;
      if (bus.rvalid0 !== 1'b1 || bus.rvalid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_valid: got rv0=%b rv1=%b want 1 0", bus.rvalid0, bus.rvalid1);
      end
      n_tests++;
      if (bus.rdata !== 8'hD0) begin
         n_fail++;
         $display("FAIL rd_data: got %h want d0", bus.rdata);
      end
      to_neg();
      idle_inputs();
      settle();
      edge_update();
      n_tests++;
      if (bus.rvalid0 !== 1'b0) begin
         n_fail++;
         $display("FAIL rd_valid_drop: got rv0=%b want 0", bus.rvalid0);
      end
      to_neg();
   endtask

   task automatic test_alternate();
      do_reset();
      idle_inputs();
      t_req     = 2'b11;
      t_addr[0] = AW'(IMAGE_BASE_ADDR);
      t_addr[1] = AW'(IMAGE_BASE_ADDR + 1);
      for (int i = 0; i < 6; i++) begin
         settle();
         n_tests++;
         if (bus.gnt0 !== (i % 2 == 0) || bus.gnt1 !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL alt_gnt[%0d]: got gnt1/0=%b%b want %b%b",
                     i, bus.gnt1, bus.gnt0, (i % 2 == 1), (i % 2 == 0));
         end
         edge_update();
         n_tests++;
         if (bus.rvalid0 !== (i % 2 == 0) || bus.rvalid1 !== (i % 2 == 1)) begin
            n_fail++;
            $display("FAIL alt_rvalid[%0d]: got rv1/0=%b%b want %b%b",
                     i, bus.rvalid1, bus.rvalid0, (i % 2 == 1), (i % 2 == 0));
         end
         to_neg();
      end
      idle_inputs();
   endtask

   task automatic test_lock_starve();
      do_reset();
      idle_inputs();
      t_req[1]  = 1'b1;
      t_lock[1] = 1'b1;
      t_addr[1] = AW'(IMAGE_BASE_ADDR + 2);
      for (int c = 0; c < 5; c++) begin
         if (c == 1) t_req[0] = 1'b1;
         settle();
         n_tests++;
         if (bus.gnt1 !== (c < 4) || bus.gnt0 !== (c == 4)) begin
            n_fail++;
            $display("FAIL starve_gnt[%0d]: got gnt1/0=%b%b want %b%b",
                     c, bus.gnt1, bus.gnt0, (c < 4), (c == 4));
         end
         edge_update();
         n_tests++;
         if (busy !== (c < 4)) begin
            n_fail++;
            $display("FAIL starve_busy[%0d]: got %b want %b", c, busy, (c < 4));
         end
         to_neg();
      end
      idle_inputs();
   endtask

   task automatic test_write_read_same();
      do_reset();
      idle_inputs();
      t_req      = 2'b11;
      t_we       = 2'b01;
      t_addr[0]  = AW'(100);
      t_addr[1]  = AW'(100);
      t_wdata[0] = 8'h5A;
      settle();
      n_tests++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_first_gnt: got gnt1/0=%b%b want 01", bus.gnt1, bus.gnt0);
      end
      n_tests++;
      if (ram_w_en !== 1'b1 || ram_address !== AW'(100) || ram_data_in !== 8'h5A) begin
         n_fail++;
         $display("FAIL wr_cmd: got w=%b addr=%0d data=%h want 1 100 5a",
                  ram_w_en, ram_address, ram_data_in);
      end
      edge_update();
      n_tests++;
      if (bus.rvalid0 !== 1'b0 || bus.rvalid1 !== 1'b0) begin
         n_fail++;
         $display("FAIL wr_no_rvalid: got rv1/0=%b%b want 00", bus.rvalid1, bus.rvalid0);
      end
      to_neg();
      t_req[0] = 1'b0;
      settle();
      n_tests++;
      if (bus.gnt1 !== 1'b1 || ram_r_en !== 1'b1) begin
         n_fail++;
         $display("FAIL rd_after_wr_gnt: got gnt1=%b r_en=%b want 1 1", bus.gnt1, ram_r_en);
      end
      edge_update();
      n_tests++;
      if (bus.rvalid1 !== 1'b1 || bus.rdata !== 8'h5A) begin
         n_fail++;
         $display("FAIL rd_after_wr_data: got rv1=%b data=%h want 1 5a", bus.rvalid1, bus.rdata);
      end
      to_neg();
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      idle_inputs();
      t_req[1]  = 1'b1;
      t_lock[1] = 1'b1;
      t_addr[1] = AW'(IMAGE_BASE_ADDR);
      for (int i = 0; i < 2; i++) begin
         settle();
         edge_update();
         to_neg();
      end
      reset = 1'b1;
      settle();
      n_tests++;
      if (bus.gnt1 !== 1'b0 || ram_r_en !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_gnt: got gnt1=%b r_en=%b want 0 0", bus.gnt1, ram_r_en);
      end
      edge_update();
      n_tests++;
      if (bus.rvalid1 !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_state: got rv1=%b busy=%b want 0 0", bus.rvalid1, busy);
      end
      to_neg();
      reset  = 1'b0;
      t_req  = 2'b11;
      t_lock = 2'b00;
      settle();
      n_tests++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_contend: got gnt1/0=%b%b want 01", bus.gnt1, bus.gnt0);
      end
      edge_update();
      to_neg();
      idle_inputs();
   endtask

   task automatic test_lock_release();
      do_reset();
      idle_inputs();
      t_req[1]  = 1'b1;
      t_lock[1] = 1'b1;
      t_addr[1] = AW'(IMAGE_BASE_ADDR + 3);
      settle();
      edge_update();
      to_neg();
      t_req[0] = 1'b1;
      settle();
      n_tests++;
      if (bus.gnt1 !== 1'b1 || bus.gnt0 !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_hold_gnt: got gnt1/0=%b%b want 10", bus.gnt1, bus.gnt0);
      end
      edge_update();
      n_tests++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL rel_hold_busy: got %b want 1", busy);
      end
      to_neg();
      t_lock[1] = 1'b0;
      settle();
      n_tests++;
      if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_gnt: got gnt1/0=%b%b want 01", bus.gnt1, bus.gnt0);
      end
      edge_update();
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rel_busy: got %b want 0", busy);
      end
      to_neg();
      idle_inputs();
   endtask

   task automatic test_random();
      logic e_wr;
      logic e_rd;
      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 63) == 0);
         for (int p = 0; p < 2; p++) begin
            t_req[p]   = ($urandom_range(0, 9) < 6);
            t_we[p]    = 1'($urandom_range(0, 1));
            t_lock[p]  = ($urandom_range(0, 9) < 4);
            t_addr[p]  = AW'(IMAGE_BASE_ADDR + $urandom_range(0, 31));
            t_wdata[p] = DW'($urandom);
         end
         settle();
         n_tests++;
         if (bus.gnt0 !== (exp_g == 0) || bus.gnt1 !== (exp_g == 1)) begin
            n_fail++;
            $display("FAIL rnd_gnt cyc %0d: got gnt1/0=%b%b want %b%b",
                     c, bus.gnt1, bus.gnt0, (exp_g == 1), (exp_g == 0));
         end
         e_wr = 1'b0;
         e_rd = 1'b0;
         if (exp_g >= 0) begin
            e_wr = t_we[exp_g];
            e_rd = !t_we[exp_g];
         end
         n_tests++;
         if (ram_w_en !== e_wr || ram_r_en !== e_rd) begin
            n_fail++;
            $display("FAIL rnd_en cyc %0d: got w/r=%b%b want %b%b", c, ram_w_en, ram_r_en, e_wr, e_rd);
         end
         if (exp_g >= 0) begin
            n_tests++;
            if (ram_address !== t_addr[exp_g]) begin
               n_fail++;
               $display("FAIL rnd_addr cyc %0d: got %0d want %0d", c, ram_address, t_addr[exp_g]);
            end
            if (e_wr) begin
               n_tests++;
               if (ram_data_in !== t_wdata[exp_g]) begin
                  n_fail++;
                  $display("FAIL rnd_wdata cyc %0d: got %h want %h", c, ram_data_in, t_wdata[exp_g]);
               end
            end
         end else if (!reset && m_hold_ok) begin
            n_tests++;
            if (ram_address !== m_hold_addr) begin
               n_fail++;
               $display("FAIL rnd_hold cyc %0d: got %0d want %0d", c, ram_address, m_hold_addr);
            end
         end
         edge_update();
         n_tests++;
         if (bus.rvalid0 !== exp_rv0 || bus.rvalid1 !== exp_rv1) begin
            n_fail++;
            $display("FAIL rnd_rvalid cyc %0d: got rv1/0=%b%b want %b%b",
                     c, bus.rvalid1, bus.rvalid0, exp_rv1, exp_rv0);
         end
         if (exp_rv0 || exp_rv1) begin
            n_tests++;
            if (bus.rdata !== exp_rdata) begin
               n_fail++;
               $display("FAIL rnd_rdata cyc %0d: got %h want %h", c, bus.rdata, exp_rdata);
            end
         end
         n_tests++;
         if (busy !== (m_owner >= 0)) begin
            n_fail++;
            $display("FAIL rnd_busy cyc %0d: got %b want %b", c, busy, (m_owner >= 0));
         end
         to_neg();
      end
      reset = 1'b0;
      idle_inputs();
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      m_owner   = -1;
      m_run     = 0;
      m_last    = 1;
      m_hold_ok = 0;
      m_hold_addr = '0;
      exp_g     = -1;
      exp_cont  = 0;
      exp_rv0   = 1'b0;
      exp_rv1   = 1'b0;
      exp_rdata = '0;
      for (int a = 0; a < RAM_WORDS; a++) begin
         ram[a]     = '0;
         ref_mem[a] = '0;
      end
      ram[IMAGE_BASE_ADDR]     = 8'hD0;
      ref_mem[IMAGE_BASE_ADDR] = 8'hD0;
      ram_data_out = '0;
      reset = 1'b1;
      idle_inputs();

      test_reset();
      test_single_read();
      test_alternate();
      test_lock_starve();
      test_write_read_same();
      test_reset_mid();
      test_lock_release();
      test_random();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single-port image RAM between two requesters: port 0, the convolution core, and port 1, the image load/dump DMA.
- Round-robin arbitration with an optional lock for bursts, bounded by a starvation limit.
- Drives the RAM's write-enable, read-enable, address and write-data inputs; returns read data with a per-port valid.
- Sits between the requesters and the RAM, which has a 1-cycle registered read.

Parameters:
DATA_WIDTH, 8, RAM word width
ADDR_WIDTH, 17, RAM address width (covers image region up to 65555+)
MAX_LOCK, 64, maximum consecutive locked grants while the other port is waiting

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  synchronous, active-high reset
req0  in  1  port 0 access request (held until granted)
we0  in  1  port 0: 1=write, 0=read
lock0  in  1  port 0 requests to keep ownership after this grant
addr0  in  ADDR_WIDTH  port 0 address
wdata0  in  DATA_WIDTH  port 0 write data
gnt0  out  1  port 0 access accepted this cycle
rvalid0  out  1  port 0 read data valid
req1/we1/lock1/addr1/wdata1  in  same as port 0, for port 1
gnt1/rvalid1  out  1  same as port 0, for port 1
rdata  out  DATA_WIDTH  read data, shared by both ports; qualified by rvalidN
ram_w_en  out  1  to RAM write enable
ram_r_en  out  1  to RAM read enable
ram_address  out  ADDR_WIDTH  to RAM address
ram_data_in  out  DATA_WIDTH  to RAM write data
ram_data_out  in  DATA_WIDTH  from RAM read data
busy  out  1  a lock is currently held

Behaviour:
- Reset values:
  - state=IDLE, last=1 (port 0 wins the first contention), lock_cnt=0.
  - rvalid0/1=0, busy=0.
  - gnt0/1, ram_w_en and ram_r_en are forced to 0 while reset is high.
- Grant timing:
  - gntN is combinational, in the same cycle as reqN.
  - The RAM command is muxed combinationally from the granted port: ram_w_en=gnt&we, ram_r_en=gnt&~we.
  - The RAM samples the command at that clock edge.
- Read latency: rvalidN is registered and asserts the cycle after a granted read; rdata=ram_data_out in that cycle.
- Writes produce no rvalid.
- One grant per cycle, with at most one of gnt0/gnt1 high.
- When not granted: ram_address and ram_data_in hold their last value; both enables are 0.
- States:
  - IDLE:
    - Only one port requesting: that port is granted.
    - Both requesting: the port != last is granted.
    - On a grant: last<=granted port. If the granted port's lock is high, go to LOCKN with lock_cnt<=1.
  - LOCKN (N owns the RAM):
    - reqN high: grant N every cycle.
    - lockN falls, or reqN low: return to IDLE and re-arbitrate in that same cycle with last=N.
    - Starvation limit: when lock_cnt==MAX_LOCK and the other port is requesting, do not grant N. Grant the other port that cycle; go to IDLE, or to the other port's LOCK if its lock is high.
    - lock_cnt saturates at MAX_LOCK if the other port is idle; it does not wrap.
- busy = (state != IDLE).
- Same-address write and read in the same cycle: serialized by arbitration. A read granted on the cycle after a write returns the new data.
- Reset mid-operation:
  - A read granted in the reset cycle produces no rvalid.
  - State and lock_cnt return to their reset values.
- No address range check; addresses pass through unchanged.

Decomposition:
- Shared package:
  - state enum: IDLE, LOCK0, LOCK1.
  - Default width constants: DATA_WIDTH=8, ADDR_WIDTH=17.
  - Image base address 20.
- One natural sub-module, rr_pick2: a combinational 2-way round-robin picker (req[1:0], last -> gnt[1:0]). The FSM, lock counter and rvalid pipeline stay in the top module.

Test Plan:
- Reset, then req0 read at addr 20 (RAM holds 8'hD0) -> gnt0 in the same cycle; next cycle rvalid0=1, rdata=8'hD0; rvalid1 stays 0.
- Both ports request continuously, no lock -> grants alternate 0,1,0,1 starting with port 0.
- lock1=1 and req1 held, req0 waiting, MAX_LOCK=4 -> gnt1 for 4 cycles, then gnt0 in cycle 5. busy=1 during the lock.
- Port 0 writes 8'h5A to addr 100 while port 1 reads addr 100 in the same cycle -> port 0 is granted first; port 1's read returns 8'h5A.
- reset asserted in the same cycle as a granted read by port 1 -> no rvalid1 the next cycle; state=IDLE; the next contention grants port 0.
- req1 with lock1 released mid-burst -> return to IDLE in the same cycle; a waiting port 0 is granted that cycle.
